dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter sharing the single-port data memory of the rv32 single-cycle system between the core load/store unit (port 0) and a debug/loader master (port 1). Grants at most one access per cycle, drives the memory port, and returns read data to the owning requester one cycle later. Sits between `rv32_single_cycle_core` and `data_memory` inside `rv32_single_cycle_top`.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits
- `MAX_WAIT`, 4, consecutive denied cycles after which port 1 wins (fixed-priority mode only), range 1..15

- `clk`  in  1  single system clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_req` / `m1_req`  in  1  access request; held with its fields stable until granted
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  ADDR_W  byte address
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data
- `m0_be` / `m1_be`  in  DATA_W/8  byte enables
- `m0_gnt` / `m1_gnt`  out  1  access accepted this cycle (combinational)
- `m0_rvalid` / `m1_rvalid`  out  1  read data valid (registered)
- `m0_rdata` / `m1_rdata`  out  DATA_W  read data, valid only with rvalid
- `mem_en`  out  1  memory access this cycle
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  —  fields of the granted requester
- `mem_rdata`  in  DATA_W  synchronous read data, one cycle after `mem_en & ~mem_we`

## Operation
- Each cycle: if exactly one `mX_req`, that port granted. If both: arbitration policy decides (below). No req → no grant, `mem_en=0`.
- `mem_en = m0_gnt | m1_gnt`; memory fields muxed from granted port; undriven fields 0 when idle.
- Fixed priority (default): port 0 wins. `wait_cnt` (4 b) increments each cycle `m1_req & ~m1_gnt`, clears on `m1_gnt` or `~m1_req`. When `wait_cnt == MAX_WAIT` and both request, port 1 wins.
- Response tracking: on a granted read, `rsp_pend_q<=1`, `rsp_owner_q<=granted port`; otherwise `rsp_pend_q<=0`. Writes produce no rvalid.
- `mX_rvalid = rsp_pend_q & (rsp_owner_q==X)`; `mX_rdata = mem_rdata` when own rvalid, else 0.
- Response state: IDLE (no pending) → RSP0/RSP1 on read grant to port 0/1; from RSPx → RSPy/IDLE per that cycle's grant. Back-to-back grants every cycle legal; a new grant may occur in the same cycle as a previous response.

## Timing
- Grant latency 0 cycles (combinational from req); read latency exactly 1 cycle after grant.
- Write completes at the grant edge; a read to the same address in the next cycle returns the new data (memory contract).
- Reset (async, any time): `rsp_pend_q=0`, `rsp_owner_q=0`, `wait_cnt=0`, RR pointer=0; all rvalid/rdata 0. While `reset_n=0`, all gnt and `mem_en` forced 0. In-flight read dropped: no rvalid after reset release.
- Simultaneous read response to port 0 and new grant to port 1: both occur in same cycle, no stall.
- `wait_cnt` saturates at `MAX_WAIT`.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin; 1-bit `last_q` records last granted port; on conflict, the port ≠ `last_q` wins; `last_q` updates on every grant; `wait_cnt` and `MAX_WAIT` unused.
- Not defined: fixed priority with starvation counter as above.

## Structure
- Shared package `rv32_pkg`: `mem_req_t` struct (we, addr, wdata, be), `arb_port_e` enum (PORT_CORE=0, PORT_DBG=1), response-state enum.
- One sub-module natural: `dmem_arb_pick` — pure policy logic (reqs, wait_cnt / last_q in → one-hot grant out).

## Test plan
- Port 0 read 0x400 alone (mem holds 0xDEADBEEF) → `m0_gnt` same cycle, `m0_rvalid=1`, `m0_rdata=0xDEADBEEF` next cycle; `m1_rvalid` stays 0.
- Both request continuously, fixed priority, `MAX_WAIT=4` → port 0 granted 4 cycles, port 1 granted on 5th, pattern repeats.
- Same with `DMEM_ARB_RR_EN` → grants alternate 0,1,0,1; each read's rvalid appears on its owner only.
- Port 1 writes 0x12345678 to 0x404 (be=4'hF), port 0 reads 0x404 next cycle → `m0_rdata=0x12345678`.
- Port 0 read granted, `reset_n` pulled low mid-cycle → gnt/`mem_en` drop immediately, no rvalid after release, `wait_cnt=0`.
- Port 0 write (no rvalid) then port 1 read back-to-back → exactly one `m1_rvalid` pulse, zero `m0_rvalid`.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types for the rv32 single-cycle system data-memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

    localparam int RV32_ADDR_W = 32;
    localparam int RV32_DATA_W = 32;
    localparam int RV32_BE_W   = RV32_DATA_W / 8;

    // One memory access as presented by a requester.
    typedef struct packed {
        logic                   we;
        logic [RV32_ADDR_W-1:0] addr;
        logic [RV32_DATA_W-1:0] wdata;
        logic [RV32_BE_W-1:0]   be;
    } mem_req_t;

    // Requester identity; the value doubles as the grant-vector bit index.
    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } arb_port_e;

    // Which requester, if any, is owed read data this cycle.
    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_P0   = 2'd1,
        RSP_P1   = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side handshake bundle of the data-memory arbiter (one per port).
// Latency: gnt is same-cycle; rvalid/rdata arrive one cycle after a read grant.
// Backpressure: requester holds req and its fields stable until gnt is seen.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    // Requester drives the access, observes grant and read response.
    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    // Arbiter observes the access, drives grant and read response.
    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Arbitration policy: two requests plus policy state in, one-hot grant out.
// Latency: purely combinational. Macro DMEM_ARB_RR_EN selects round-robin.
// Backpressure: none; a lone request is always granted, a conflict picks one.
module dmem_arb_pick
    import rv32_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
    input  logic       last_i,
`else
    input  logic [3:0] wait_cnt_i,
`endif
    output logic [1:0] gnt_o
);

`ifndef DMEM_ARB_RR_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
`endif

    // Lone requests win outright; conflicts go to the policy.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01: gnt_o[PORT_CORE] = 1'b1;
            2'b10: gnt_o[PORT_DBG]  = 1'b1;
            2'b11: begin
`ifdef DMEM_ARB_RR_EN
                // The port that did not win last time goes now.
                if (last_i == PORT_DBG) gnt_o[PORT_CORE] = 1'b1;
                else                    gnt_o[PORT_DBG]  = 1'b1;
`else
                // Core wins unless the debug port has waited long enough.
                if (wait_cnt_i == MAX_WAIT_C) gnt_o[PORT_DBG]  = 1'b1;
                else                          gnt_o[PORT_CORE] = 1'b1;
`endif
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between core LSU (m0) and debug/loader (m1).
// Latency: grant 0 cycles, read data exactly 1 cycle after grant. Macro DMEM_ARB_RR_EN.
// Backpressure: losing requester sees gnt=0 and must hold its request; no stalls on responses.
module dmem_port_arbiter
    import rv32_pkg::*;
#(
    // Bus widths must match the rv32_pkg request struct.
    parameter int ADDR_W   = RV32_ADDR_W,
    parameter int DATA_W   = RV32_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dmem_port_arbiter_if.slave    m0,
    dmem_port_arbiter_if.slave    m1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
);

    mem_req_t   req0, req1, sel_req;
    logic [1:0] pick_gnt;
    logic       gnt0, gnt1;
    logic       rd_gnt;
    arb_port_e  rd_port;
    rsp_state_e rsp_state_q, rsp_state_d;
    logic       rsp_pend;
    arb_port_e  rsp_owner;
    logic       rvalid0, rvalid1;

    // Gather each requester's fields into the shared request record.
    always_comb begin
        req0 = '{we: m0.we, addr: m0.addr, wdata: m0.wdata, be: m0.be};
        req1 = '{we: m1.we, addr: m1.addr, wdata: m1.wdata, be: m1.be};
    end

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // Remember which port won the most recent grant.
    always_comb begin
        last_d = last_q;
        if (mem_en) last_d = gnt1;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b0;
        else          last_q <= last_d;
    end

    dmem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .req_i  ({m1.req, m0.req}),
        .last_i (last_q),
        .gnt_o  (pick_gnt)
    );
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // Count consecutive cycles the debug port asks but loses; saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!m1.req || gnt1)              wait_cnt_d = '0;
        else if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wait_cnt_q <= '0;
        else          wait_cnt_q <= wait_cnt_d;
    end

    dmem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .req_i      ({m1.req, m0.req}),
        .wait_cnt_i (wait_cnt_q),
        .gnt_o      (pick_gnt)
    );
`endif

    // Grants are killed combinationally while reset is asserted.
    assign gnt0   = pick_gnt[PORT_CORE] & reset_n;
    assign gnt1   = pick_gnt[PORT_DBG]  & reset_n;
    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    // Route the granted requester's fields to the memory; idle drives zeros.
    always_comb begin
        sel_req = '0;
        if (gnt1)      sel_req = req1;
        else if (gnt0) sel_req = req0;
    end

    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = sel_req.we;
    assign mem_addr  = sel_req.addr;
    assign mem_wdata = sel_req.wdata;
    assign mem_be    = sel_req.be;

    assign rd_gnt  = mem_en & ~sel_req.we;
    assign rd_port = gnt1 ? PORT_DBG : PORT_CORE;

    // Response state register; an in-flight read is dropped by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rsp_state_q <= RSP_IDLE;
        else          rsp_state_q <= rsp_state_d;
    end

    // This cycle's read grant alone decides who is owed data next cycle.
    always_comb begin
        rsp_state_d = RSP_IDLE;
        if (rd_gnt) rsp_state_d = (rd_port == PORT_DBG) ? RSP_P1 : RSP_P0;
    end

    // Decode the response state into pending flag and owner.
    always_comb begin
        rsp_pend  = 1'b0;
        rsp_owner = PORT_CORE;
        case (rsp_state_q)
            RSP_P0:  rsp_pend = 1'b1;
            RSP_P1: begin
                rsp_pend  = 1'b1;
                rsp_owner = PORT_DBG;
            end
            default: rsp_pend = 1'b0;
        endcase
    end

    assign rvalid0   = rsp_pend & (rsp_owner == PORT_CORE);
    assign rvalid1   = rsp_pend & (rsp_owner == PORT_DBG);
    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = rvalid0 ? mem_rdata : '0;
    assign m1.rdata  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } pin_t;

    typedef struct {
        pin_t        p0;
        pin_t        p1;
        logic        g0;
        logic        g1;
        logic        v0;
        logic        v1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port memory sitting behind the arbiter.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[11:2]];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    pin_t        p_cur [2];
    logic        p_gnt [2];
    int          m_streak;
    int          m_last;
    logic        m_pend;
    int          m_owner;
    logic [31:0] m_data;

    vec_t vecs[$];

    function automatic pin_t idle();
        return '0;
    endfunction

    function automatic pin_t rd(input logic [31:0] a);
        pin_t p;
        p = '0; p.req = 1'b1; p.addr = a; p.be = 4'hF;
        return p;
    endfunction

    function automatic pin_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        pin_t p;
        p = '0; p.req = 1'b1; p.we = 1'b1; p.addr = a; p.wdata = d; p.be = b;
        return p;
    endfunction

    function automatic vec_t mk(input pin_t a, input pin_t b, input logic g0, input logic g1,
                                input logic v0, input logic v1, input logic [31:0] rd0,
                                input logic [31:0] rd1);
        vec_t v;
        v.p0 = a; v.p1 = b; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input pin_t a, input pin_t b);
        m0_if.req = a.req; m0_if.we = a.we; m0_if.addr = a.addr; m0_if.wdata = a.wdata; m0_if.be = a.be;
        m1_if.req = b.req; m1_if.we = b.we; m1_if.addr = b.addr; m1_if.wdata = b.wdata; m1_if.be = b.be;
    endtask

    task automatic do_reset();
        drive(idle(), idle());
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_streak = 0; m_last = 0; m_pend = 1'b0; m_owner = 0; m_data = '0;
        p_cur[0] = idle(); p_cur[1] = idle(); p_gnt[0] = 1'b0; p_gnt[1] = 1'b0;
    endtask

    // One cycle against the reference model: apply p_cur, compare, advance model.
    task automatic model_cycle(input string tag);
        logic e0, e1, ev0, ev1;
        int   sel, idx;
        @(posedge clk); #1;
        drive(p_cur[0], p_cur[1]);
        if (p_cur[0].req && p_cur[1].req) begin
`ifdef DMEM_ARB_RR_EN
            e1 = (m_last == 0);
`else
            e1 = (m_streak >= MAX_WAIT);
`endif
            e0 = !e1;
        end else begin
            e0 = p_cur[0].req;
            e1 = p_cur[1].req;
        end
        sel = e1 ? 1 : 0;
        ev0 = m_pend && (m_owner == 0);
        ev1 = m_pend && (m_owner == 1);
        @(negedge clk);
        chk({tag, "_gnt0"}, m0_if.gnt, e0);
        chk({tag, "_gnt1"}, m1_if.gnt, e1);
        chk({tag, "_mem_en"}, mem_en, e0 | e1);
        if (e0 || e1) begin
            chk({tag, "_mem_we"}, mem_we, p_cur[sel].we);
            chk({tag, "_mem_addr"}, mem_addr, p_cur[sel].addr);
            if (p_cur[sel].we) begin
                chk({tag, "_mem_wdata"}, mem_wdata, p_cur[sel].wdata);
                chk({tag, "_mem_be"}, mem_be, p_cur[sel].be);
            end
        end
        chk({tag, "_rvalid0"}, m0_if.rvalid, ev0);
        chk({tag, "_rvalid1"}, m1_if.rvalid, ev1);
        chk({tag, "_rdata0"}, m0_if.rdata, ev0 ? m_data : 32'h0);
        chk({tag, "_rdata1"}, m1_if.rdata, ev1 ? m_data : 32'h0);
        m_pend = 1'b0;
        if (e0 || e1) begin
            idx = int'(p_cur[sel].addr[11:2]);
            if (p_cur[sel].we) begin
                for (int b = 0; b < 4; b++)
                    if (p_cur[sel].be[b]) ref_mem[idx][8*b +: 8] = p_cur[sel].wdata[8*b +: 8];
            end else begin
                m_pend  = 1'b1;
                m_owner = sel;
                m_data  = ref_mem[idx];
            end
            m_last = sel;
        end
        if (p_cur[1].req && !e1) m_streak++;
        else                     m_streak = 0;
        p_gnt[0] = e0;
        p_gnt[1] = e1;
    endtask

    initial begin
        logic e1, pg0, pg1;

        // Reset: requests present but everything held quiet.
        reset_n = 1'b0;
        drive(rd(32'h400), wr(32'h404, 32'h1, 4'hF));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", m0_if.gnt, 0);
        chk("rst_gnt1", m1_if.gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid0", m0_if.rvalid, 0);
        chk("rst_rvalid1", m1_if.rvalid, 0);
        chk("rst_rdata0", m0_if.rdata, 0);
        @(posedge clk); #1;
        drive(idle(), idle());
        reset_n = 1'b1;

        // Directed vectors, one row per cycle; rvalid columns refer to the previous row's grant.
        vecs.push_back(mk(idle(), idle(), 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(idle(), wr(32'h400, 32'hDEADBEEF, 4'hF), 0, 1, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(idle(), wr(32'h408, 32'h00000000, 4'hF), 0, 1, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(rd(32'h400), idle(), 1, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(idle(), idle(), 0, 0, 1, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(idle(), wr(32'h404, 32'h12345678, 4'hF), 0, 1, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(rd(32'h404), idle(), 1, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(idle(), rd(32'h400), 0, 1, 1, 0, 32'h12345678, 32'h0));
        vecs.push_back(mk(wr(32'h408, 32'hAABBCCDD, 4'h3), idle(), 1, 0, 0, 1, 32'h0, 32'hDEADBEEF));
        vecs.push_back(mk(idle(), rd(32'h408), 0, 1, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(idle(), idle(), 0, 0, 0, 1, 32'h0, 32'h0000CCDD));
        vecs.push_back(mk(idle(), idle(), 0, 0, 0, 0, 32'h0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].p0, vecs[i].p1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt0", i), m0_if.gnt, vecs[i].g0);
            chk($sformatf("vec%0d_gnt1", i), m1_if.gnt, vecs[i].g1);
            chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].g0 | vecs[i].g1);
            chk($sformatf("vec%0d_rvalid0", i), m0_if.rvalid, vecs[i].v0);
            chk($sformatf("vec%0d_rvalid1", i), m1_if.rvalid, vecs[i].v1);
            chk($sformatf("vec%0d_rdata0", i), m0_if.rdata, vecs[i].rd0);
            chk($sformatf("vec%0d_rdata1", i), m1_if.rdata, vecs[i].rd1);
        end

        // Both ports hammer reads of 0x400: starvation breaker / alternation.
        pg0 = 1'b0; pg1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            drive(rd(32'h400), rd(32'h400));
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            e1 = (k % 2 == 1);
`else
            e1 = (k % 5 == 4);
`endif
            chk($sformatf("starve%0d_gnt0", k), m0_if.gnt, !e1);
            chk($sformatf("starve%0d_gnt1", k), m1_if.gnt, e1);
            chk($sformatf("starve%0d_rvalid0", k), m0_if.rvalid, pg0);
            chk($sformatf("starve%0d_rvalid1", k), m1_if.rvalid, pg1);
            chk($sformatf("starve%0d_rdata0", k), m0_if.rdata, pg0 ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("starve%0d_rdata1", k), m1_if.rdata, pg1 ? 32'hDEADBEEF : 32'h0);
            pg0 = !e1; pg1 = e1;
        end
        @(posedge clk); #1;
        drive(idle(), idle());
        @(negedge clk);
        chk("starve_tail_rvalid0", m0_if.rvalid, pg0);
        chk("starve_tail_rvalid1", m1_if.rvalid, pg1);

        // Build up port-1 waiting, then reset in the middle of a granted read.
        repeat (3) begin
            @(posedge clk); #1;
            drive(rd(32'h400), rd(32'h404));
        end
        @(posedge clk); #1;
        drive(rd(32'h400), rd(32'h404));
        #1;
        chk("midrst_pre_mem_en", mem_en, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_gnt0", m0_if.gnt, 0);
        chk("midrst_gnt1", m1_if.gnt, 0);
        chk("midrst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        drive(idle(), idle());
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_post_rvalid0", m0_if.rvalid, 0);
        chk("midrst_post_rvalid1", m1_if.rvalid, 0);
        @(negedge clk);
        chk("midrst_post2_rvalid0", m0_if.rvalid, 0);
        // Policy state must restart from its reset value.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(rd(32'h400), rd(32'h400));
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            e1 = (k % 2 == 0);
`else
            e1 = (k == 4);
`endif
            chk($sformatf("recover%0d_gnt1", k), m1_if.gnt, e1);
            chk($sformatf("recover%0d_gnt0", k), m0_if.gnt, !e1);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            p_cur[0] = wr(32'h400 + 32'(4 * i), $urandom, 4'hF);
            p_cur[1] = idle();
            model_cycle("load");
        end
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_cur[p].req || p_gnt[p]) begin
                    p_cur[p].req   = ($urandom_range(0, 3) != 0);
                    p_cur[p].we    = $urandom_range(0, 1) == 1;
                    p_cur[p].addr  = 32'h400 + 32'(4 * $urandom_range(0, 15));
                    p_cur[p].wdata = $urandom;
                    p_cur[p].be    = 4'($urandom_range(1, 15));
                end
            end
            model_cycle("rnd");
        end
        p_cur[0] = idle();
        p_cur[1] = idle();
        model_cycle("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
